// File: rtl/prog_up_down_counter.sv
// Loadable up/down counter with enable, clock prescaler, one-shot or
// auto-reload mode, a one-cycle terminal-count pulse R and a running flag.
module prog_up_down_counter #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] val,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             R,
    output logic             running
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] reload;
    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] term;
    logic             step;

    // Terminal value follows dir as sampled on this edge, so a mid-count
    // direction change retargets the count immediately.
    assign term = dir ? '0 : '1;
    assign step = running && en && (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            reload  <= '0;
            pre     <= '0;
            running <= 1'b0;
            R       <= 1'b0;
        end else if (load) begin
            count   <= val;
            reload  <= val;
            pre     <= '0;
            running <= 1'b1;
            R       <= 1'b0;
        end else if (step) begin
            pre <= '0;
            if (count == term) begin
                R <= 1'b1;
                if (mode) count   <= reload;
                else      running <= 1'b0;
            end else begin
                R     <= 1'b0;
                count <= dir ? count - 1'b1 : count + 1'b1;
            end
        end else begin
            R <= 1'b0;
            if (running && en) pre <= pre + 1'b1;
        end
    end
endmodule

// File: tb/tb_prog_up_down_counter.sv
// Bench for prog_up_down_counter: a PRESCALE=1 and a PRESCALE=3 instance share
// stimulus; vectors, directed sequences and random traffic vs. a reference model.
module tb_prog_up_down_counter;
    logic       clk = 1'b0;
    logic       rst, en, load, dir, mode;
    logic [3:0] val;
    logic [3:0] count_a, count_b;
    logic       r_a, r_b, running_a, running_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_up_down_counter #(.WIDTH(4), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .val(val), .dir(dir),
        .mode(mode), .count(count_a), .R(r_a), .running(running_a)
    );

    prog_up_down_counter #(.WIDTH(4), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .val(val), .dir(dir),
        .mode(mode), .count(count_b), .R(r_b), .running(running_b)
    );

    // Reference model: plain integers, one call per rising edge.
    typedef struct {
        int cnt;
        int rel;
        int pre;
        int run;
        int r;
    } mstate_t;

    mstate_t ma = '{0, 0, 0, 0, 0};
    mstate_t mb = '{0, 0, 0, 0, 0};

    function automatic mstate_t mstep(mstate_t s, int p);
        mstate_t n = s;
        int term;
        n.r = 0;
        if (rst) begin
            n = '{0, 0, 0, 0, 0};
        end else if (load) begin
            n.cnt = int'(val);
            n.rel = int'(val);
            n.pre = 0;
            n.run = 1;
        end else if (s.run != 0 && en) begin
            if (s.pre + 1 < p) begin
                n.pre = s.pre + 1;
            end else begin
                n.pre = 0;
                term  = dir ? 0 : 15;
                if (s.cnt == term) begin
                    n.r = 1;
                    if (mode) n.cnt = s.rel;
                    else      n.run = 0;
                end else begin
                    n.cnt = (s.cnt + (dir ? 15 : 1)) % 16;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic l,
                         input logic [3:0] v, input logic d, input logic m);
        rst = r; en = e; load = l; val = v; dir = d; mode = m;
    endtask

    // Advance one edge, step both models, compare both instances.
    task automatic tick(input string ph);
        @(posedge clk);
        ma = mstep(ma, 1);
        mb = mstep(mb, 3);
        #1;
        chk({ph, " a.count"},   int'(count_a),   ma.cnt);
        chk({ph, " a.R"},       int'(r_a),       ma.r);
        chk({ph, " a.running"}, int'(running_a), ma.run);
        chk({ph, " b.count"},   int'(count_b),   mb.cnt);
        chk({ph, " b.R"},       int'(r_b),       mb.r);
        chk({ph, " b.running"}, int'(running_b), mb.run);
    endtask

    typedef struct {
        logic       rst, en, load;
        logic [3:0] val;
        logic       dir, mode;
        logic [3:0] cnt;
        logic       r, run;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic l,
                                input logic [3:0] v, input logic d, input logic m,
                                input logic [3:0] c, input logic rr, input logic run);
        vec_t t;
        t.rst = r; t.en = e; t.load = l; t.val = v; t.dir = d; t.mode = m;
        t.cnt = c; t.r = rr; t.run = run;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        drive(1, 1, 0, 0, 0, 0);

        // Reset, reset-vs-load, then the up one-shot from 7 on the PRESCALE=1 unit.
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 9, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 7, 0, 0, 7, 0, 1));
        for (int k = 8; k <= 15; k++)
            tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'(k), 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 15, 1, 0));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(0, 1, 0, 0, 0, 0, 15, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].val, tbl[i].dir, tbl[i].mode);
            tick("vec");
            chk($sformatf("vec%0d count", i), int'(count_a),   int'(tbl[i].cnt));
            chk($sformatf("vec%0d R", i),     int'(r_a),       int'(tbl[i].r));
            chk($sformatf("vec%0d running", i), int'(running_a), int'(tbl[i].run));
        end

        // Down auto-reload from 3: 3,2,1,0,3,... with R on each reload.
        drive(0, 1, 1, 3, 1, 1);
        tick("down");
        chk("down load count", int'(count_a), 3);
        drive(0, 1, 0, 0, 1, 1);
        for (int k = 1; k <= 12; k++) begin
            tick("down");
            chk($sformatf("down%0d count", k), int'(count_a), 3 - (k % 4));
            chk($sformatf("down%0d R", k), int'(r_a), (k % 4 == 0) ? 1 : 0);
            chk($sformatf("down%0d running", k), int'(running_a), 1);
        end

        // Enable gating at 10, then load collision on the terminal edge at 15.
        drive(0, 1, 1, 7, 0, 0);
        tick("gate");
        drive(0, 1, 0, 0, 0, 0);
        repeat (3) tick("gate");
        chk("gate at10", int'(count_a), 10);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick("gate");
            chk("gate hold count", int'(count_a), 10);
            chk("gate hold R", int'(r_a), 0);
        end
        drive(0, 1, 0, 0, 0, 0);
        tick("gate");
        chk("gate resume", int'(count_a), 11);
        repeat (4) tick("coll");
        chk("coll at15", int'(count_a), 15);
        drive(0, 1, 1, 2, 0, 0);
        tick("coll");
        chk("coll count", int'(count_a), 2);
        chk("coll R", int'(r_a), 0);
        chk("coll running", int'(running_a), 1);

        // Prescaler: 14 for 3 cycles, 15 for 3, R after 6th enabled edge.
        drive(0, 1, 1, 14, 0, 0);
        tick("psc");
        chk("psc e0", int'(count_b), 14);
        drive(0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            tick("psc");
            chk($sformatf("psc e%0d count", k), int'(count_b), (k < 3) ? 14 : 15);
            chk($sformatf("psc e%0d R", k), int'(r_b), (k == 6) ? 1 : 0);
            chk($sformatf("psc e%0d running", k), int'(running_b), (k < 6) ? 1 : 0);
        end

        // Two disabled cycles mid-interval stretch it by exactly two edges.
        drive(0, 1, 1, 14, 0, 0);
        tick("str");
        drive(0, 1, 0, 0, 0, 0);
        tick("str");
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick("str");
        drive(0, 1, 0, 0, 0, 0);
        tick("str");
        chk("str e4", int'(count_b), 14);
        tick("str");
        chk("str e5", int'(count_b), 15);

        // Randomised traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 11) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0) ? ~dir : dir,
                  ($urandom_range(0, 1) == 1));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_up_down_counter.md
Name: prog_up_down_counter

Overview:
- Parametrised successor to the 4-bit loadable up counter. Adds configurable width, count direction, one-shot/auto-reload mode, enable gating, clock prescaler and explicit synchronous reset.
- Produces a one-cycle terminal-count pulse (R) and a running flag.
- Used as the sequencing/timing counter feeding adder control logic.

Parameters:
- WIDTH, 4, bit width of count, val and the reload register.
- PRESCALE, 1, number of enabled cycles per count step; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; gates prescaler and count.
- load  input  1  load val into count and reload register, start running.
- val  input  WIDTH  load value.
- dir  input  1  0 = count up toward all-ones; 1 = count down toward zero.
- mode  input  1  0 = one-shot; 1 = auto-reload.
- count  output  WIDTH  current count, registered.
- R  output  1  terminal-count pulse, registered, high for exactly one cycle.
- running  output  1  counter armed and counting.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Internal state:
  - reload register, WIDTH bits.
  - prescaler pre, clog2(PRESCALE) bits (at least 1).
- Reset values: count=0, reload=0, pre=0, running=0, R=0.
- TERM = {WIDTH{1'b1}} when dir=0; TERM = 0 when dir=1. TERM is evaluated with dir as sampled on the current edge.
- step = running && en && (pre == PRESCALE-1).
- Priority per rising edge, highest first:
  1. rst: all state goes to reset values. Overrides load and every other input.
  2. load: count<=val, reload<=val, pre<=0, running<=1, R<=0. Overrides step and terminal.
  3. step && count==TERM (terminal event):
     - R<=1 and pre<=0.
     - mode=1: count<=reload; running stays 1.
     - mode=0: count holds TERM; running<=0.
  4. step && count!=TERM: count<=count+1 (dir=0) or count-1 (dir=1). pre<=0. R<=0.
  5. running && en && !step: pre<=pre+1. count holds, R<=0.
  6. Otherwise (en=0 or running=0): count and pre hold, R<=0.
- R rules:
  - R is high only in the cycle following a terminal-event edge.
  - In auto-reload, back-to-back terminal events are impossible with PRESCALE=1 unless reload==TERM. In that case R stays high on every step, which is legal.
- Loading val==TERM: the first step after the load is a terminal event, so R fires after PRESCALE enabled cycles.
- Arithmetic is modulo 2^WIDTH. Wrap-around never occurs in practice because the terminal event intercepts it.
- dir toggled mid-count takes effect on the next edge. The count continues from its present value toward the new TERM.
- After one-shot completion (running=0), en has no effect until the next load.
- With PRESCALE=1, pre is constant 0 and step = running && en.

Test Plan:
- Reset, WIDTH=4, PRESCALE=1: assert rst 2 cycles with en=1, load=0 -> count=0, R=0, running=0 and held. Assert rst together with load=1, val=9 -> rst wins, count=0.
- Up one-shot: val=7, dir=0, mode=0, en=1, load pulse on edge t0 -> count=7 at t0, then 8..15 at t1..t8. R=1 only during the cycle after t9. running=0 after t9. count stays 15 for 10 more cycles.
- Down auto-reload: val=3, dir=1, mode=1 -> count sequence 3,2,1,0,3,2,1,0,... R pulses once every 4 cycles, aligned with each 0->3 reload. running stays 1.
- Enable gating: during the up count at count=10, drop en for 5 cycles -> count holds 10, R=0. Counting resumes at 11 on the first edge with en=1.
- Load collision: on the edge where count=15 would cause a terminal event, assert load with val=2 -> R stays 0, count=2, running=1.
- Prescaler, PRESCALE=3: val=14, dir=0, mode=0, en=1 -> count=14 for 3 cycles, then 15 for 3 cycles. R=1 one cycle after the 6th enabled edge. Holding en=0 for 2 cycles mid-interval stretches the interval by exactly 2 cycles.
